// File: rtl/da_serial_accumulator.sv
// Distributed-arithmetic FIR control/accumulate stage. It loads a sample into the bit-serial
// subfilter, shift-accumulates the ROM words it returns, and hands back one saturated output.
module da_serial_accumulator #(
  parameter int                    word_width  = 16,
  parameter bit                    offset_mode = 1'b0,
  parameter logic [word_width-1:0] Q0_initial  = 16'h1312
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] x_in,
  input  logic                  x_valid,
  output logic                  x_ready,
  output logic [word_width-1:0] sub_x,
  output logic                  sub_x_we,
  output logic                  sub_en,
  output logic                  sub_Ts,
  input  logic [word_width-1:0] rom_data,
  output logic [word_width-1:0] y,
  output logic                  y_valid,
  input  logic                  y_ready
);

  localparam int AW = word_width + 2;
  localparam int KW = (word_width > 2) ? $clog2(word_width) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(word_width - 1);
  localparam logic signed [AW-1:0] SAT_MAX = {3'b000, {(word_width-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {3'b111, {(word_width-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD} state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [KW-1:0]           r_k;
  logic signed [AW-1:0]    r_acc;
  logic [word_width-1:0]   r_sub_x;
  logic [word_width-1:0]   r_y;

  logic                    w_last;
  logic signed [AW-1:0]    w_rom_ext;
  logic signed [AW-1:0]    w_q0_ext;
  logic signed [AW-1:0]    w_sum;
  logic [word_width-1:0]   w_y_sat;

  assign w_last    = (r_state == S_RUN) && (r_k == K_LAST);
  assign w_rom_ext = {{2{rom_data[word_width-1]}}, rom_data};
  assign w_q0_ext  = offset_mode ? {{2{Q0_initial[word_width-1]}}, Q0_initial} : '0;

  // The sign-bit cycle carries negative weight, so its ROM word is subtracted.
  assign w_sum = w_last ? (r_acc - w_rom_ext + w_q0_ext) : (r_acc + w_rom_ext);

  always_comb begin
    if (w_sum > SAT_MAX) begin
      w_y_sat = SAT_MAX[word_width-1:0];
    end else if (w_sum < SAT_MIN) begin
      w_y_sat = SAT_MIN[word_width-1:0];
    end else begin
      w_y_sat = w_sum[word_width-1:0];
    end
  end

  always_comb begin
    w_next_state = r_state;
    x_ready      = 1'b0;
    sub_x_we     = 1'b0;
    sub_en       = 1'b0;
    sub_Ts       = 1'b0;
    y_valid      = 1'b0;
    case (r_state)
      S_IDLE: begin
        x_ready = 1'b1;
        if (x_valid) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        sub_x_we     = 1'b1;
        sub_en       = 1'b1;
        w_next_state = S_RUN;
      end
      S_RUN: begin
        sub_en = 1'b1;
        sub_Ts = w_last;
        if (w_last) w_next_state = S_HOLD;
      end
      S_HOLD: begin
        y_valid = 1'b1;
        if (y_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_acc   <= '0;
      r_sub_x <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (x_valid) begin
            r_sub_x <= x_in;
            r_acc   <= '0;
            r_k     <= '0;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_y <= w_y_sat;
          end else begin
            r_acc <= w_sum >>> 1;
            r_k   <= r_k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sub_x = r_sub_x;
  assign y     = r_y;

endmodule
